// File: rtl/lsu_mem_port_if.sv
// rtl/lsu_mem_port_if.sv - pipeline request/response and word-memory port bundle for lsu_mem_port
interface lsu_mem_port_if #(
  parameter int ADDR = 16,
  parameter int WORD = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [1:0]      req_size;
  logic            req_signed;
  logic [ADDR+1:0] req_addr;
  logic [WORD-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_err;
  logic [WORD-1:0] rsp_rdata;
  logic [ADDR-1:0] mem_A;
  logic            mem_W;
  logic [WORD-1:0] mem_D;
  logic [WORD-1:0] mem_Q;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_Q,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_A, mem_W, mem_D
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_Q,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_A, mem_W, mem_D
  );
endinterface

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - load/store sequencer onto a synchronous-read 32-bit word memory port
// Define LSU_SUBWORD_EN for byte/half accesses with read-modify-write sub-word stores.
module lsu_mem_port #(
  parameter int ADDR = 16,
  parameter int WORD = 32
) (
  input  logic           clk_i,
  input  logic           reset_i,
  lsu_mem_port_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    ST_DONE,
    RD1,
`ifdef LSU_SUBWORD_EN
    RD2,
    WR
`else
    RD2
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [ADDR-1:0] mem_a_q, mem_a_d;
  logic            mem_w_q, mem_w_d;
  logic [WORD-1:0] mem_d_q, mem_d_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [WORD-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            accept;
  logic            misaligned;
  logic            word_store;

`ifdef LSU_SUBWORD_EN
  logic            write_q, write_d;
  logic [1:0]      size_q, size_d;
  logic            signed_q, signed_d;
  logic [1:0]      lane_q, lane_d;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [WORD-1:0] load_ext;
  logic [WORD-1:0] merged;

  always_comb begin
    misaligned = 1'b0;
    if (bus.req_size[1]) begin
      misaligned = (bus.req_addr[1:0] != 2'b00);
    end else if (bus.req_size[0]) begin
      misaligned = bus.req_addr[0];
    end
  end

  assign word_store = bus.req_write && bus.req_size[1];

  assign byte_sel = bus.mem_Q[{lane_q, 3'b000} +: 8];
  assign half_sel = bus.mem_Q[{lane_q[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = bus.mem_Q;
    if (size_q == 2'b00) begin
      load_ext = {{(WORD-8){signed_q & byte_sel[7]}}, byte_sel};
    end else if (size_q == 2'b01) begin
      load_ext = {{(WORD-16){signed_q & half_sel[15]}}, half_sel};
    end
  end

  // mem_d_q still holds the right-aligned store data until the merge replaces it
  always_comb begin
    merged = bus.mem_Q;
    for (int b = 0; b < 4; b++) begin
      if (size_q == 2'b00 && lane_q == b[1:0]) begin
        merged[8*b +: 8] = mem_d_q[7:0];
      end
      if (size_q == 2'b01 && lane_q[1] == b[1]) begin
        merged[8*b +: 8] = mem_d_q[8*(b%2) +: 8];
      end
    end
  end
`else
  logic unused_req_fields;

  assign unused_req_fields = ^{bus.req_size, bus.req_signed};
  assign misaligned        = (bus.req_addr[1:0] != 2'b00);
  assign word_store        = bus.req_write;
`endif

  assign bus.req_ready = (state_q == IDLE) && !reset_i;
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d     = state_q;
    mem_a_d     = mem_a_q;
    mem_w_d     = 1'b0;
    mem_d_d     = mem_d_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
`ifdef LSU_SUBWORD_EN
    write_d     = write_q;
    size_d      = size_q;
    signed_d    = signed_q;
    lane_d      = lane_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (misaligned) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            mem_a_d = bus.req_addr[ADDR+1:2];
            mem_d_d = bus.req_wdata;
            mem_w_d = word_store;
            state_d = word_store ? ST_DONE : RD1;
`ifdef LSU_SUBWORD_EN
            write_d  = bus.req_write;
            size_d   = bus.req_size;
            signed_d = bus.req_signed;
            lane_d   = bus.req_addr[1:0];
`endif
          end
        end
      end
      ST_DONE: begin
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      RD1: begin
        state_d = RD2;
      end
      RD2: begin
`ifdef LSU_SUBWORD_EN
        if (write_q) begin
          mem_d_d = merged;
          mem_w_d = 1'b1;
          state_d = WR;
        end else begin
          rsp_rdata_d = load_ext;
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end
`else
        rsp_rdata_d = bus.mem_Q;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
`endif
      end
`ifdef LSU_SUBWORD_EN
      WR: begin
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Asynchronous clear of mem_w_q keeps a write in flight from landing in memory
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      mem_a_q     <= '0;
      mem_w_q     <= 1'b0;
      mem_d_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef LSU_SUBWORD_EN
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      lane_q      <= 2'b00;
`endif
    end else begin
      state_q     <= state_d;
      mem_a_q     <= mem_a_d;
      mem_w_q     <= mem_w_d;
      mem_d_q     <= mem_d_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef LSU_SUBWORD_EN
      write_q     <= write_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      lane_q      <= lane_d;
`endif
    end
  end

  assign bus.mem_A     = mem_a_q;
  assign bus.mem_W     = mem_w_q;
  assign bus.mem_D     = mem_d_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb/tb_lsu_mem_port.sv - self-checking bench for lsu_mem_port (either LSU_SUBWORD_EN build)
module tb_lsu_mem_port;
  localparam int ADDR = 16;
  localparam int WORD = 32;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [17:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          wcnt;
    int          wcyc;
    logic [31:0] wd;
  } res_t;

  typedef struct {
    req_t r;
    res_t e;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] mem     [0:65535];
  logic [31:0] ref_mem [0:65535];

  always #5 clk = ~clk;

  lsu_mem_port_if #(.ADDR(ADDR), .WORD(WORD)) ifc ();

  lsu_mem_port #(.ADDR(ADDR), .WORD(WORD)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (ifc.master)
  );

  // Word memory: Q returns the word addressed at the previous edge (read-before-write)
  initial begin
    logic [31:0] q;
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    forever begin
      @(posedge clk);
      q = mem[ifc.mem_A];
      if (ifc.mem_W) mem[ifc.mem_A] = ifc.mem_D;
      ifc.mem_Q <= q;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference: access size in bytes, alignment by modulo, lanes by shifting
  function automatic res_t model(input req_t r);
    res_t        e;
    int          nb;
    int          off;
    int          wa;
    logic [31:0] mask;
    logic [31:0] v;
`ifdef LSU_SUBWORD_EN
    nb = (r.size == 2'd0) ? 1 : (r.size == 2'd1) ? 2 : 4;
`else
    nb = 4;
`endif
    off     = int'(r.addr) % 4;
    wa      = int'(r.addr) / 4;
    mask    = (nb == 1) ? 32'hFF : (nb == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    e.err   = 1'b0;
    e.rdata = '0;
    e.wcnt  = 0;
    e.wcyc  = 0;
    e.wd    = '0;
    if (int'(r.addr) % nb != 0) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (!r.wr) begin
      v = (ref_mem[wa] >> (8 * off)) & mask;
      if (r.sgn && nb < 4 && v[8*nb-1]) v = v | ~mask;
      e.rdata = v;
      e.lat   = 3;
    end else begin
      ref_mem[wa] = (ref_mem[wa] & ~(mask << (8 * off))) | ((r.wdata & mask) << (8 * off));
      e.wd   = ref_mem[wa];
      e.wcnt = 1;
      e.wcyc = (nb == 4) ? 1 : 3;
      e.lat  = (nb == 4) ? 2 : 4;
    end
    return e;
  endfunction

  function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic sg,
                              input logic [17:0] a, input logic [31:0] wdat,
                              input logic err, input logic [31:0] rd, input int lat,
                              input int wcyc, input logic [31:0] wword);
    vec_t v;
    v.r.wr    = wr;
    v.r.size  = sz;
    v.r.sgn   = sg;
    v.r.addr  = a;
    v.r.wdata = wdat;
    v.e.err   = err;
    v.e.rdata = rd;
    v.e.lat   = lat;
    v.e.wcyc  = wcyc;
    v.e.wcnt  = (wcyc != 0) ? 1 : 0;
    v.e.wd    = wword;
    return v;
  endfunction

  task automatic drive(input req_t r, input logic valid);
    ifc.req_valid  = valid;
    ifc.req_write  = r.wr;
    ifc.req_size   = r.size;
    ifc.req_signed = r.sgn;
    ifc.req_addr   = r.addr;
    ifc.req_wdata  = r.wdata;
  endtask

  task automatic do_req(input req_t r, output res_t o, output logic a_ok);
    logic        done;
    logic [15:0] wa;
    wa     = r.addr[17:2];
    o.err  = 1'b0;
    o.rdata = '0;
    o.lat  = -1;
    o.wcnt = 0;
    o.wcyc = 0;
    o.wd   = '0;
    a_ok   = 1'b1;
    done   = 1'b0;
    drive(r, 1'b1);
    chk("req_ready_at_issue", {31'd0, ifc.req_ready}, 32'd1);
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
    for (int n = 1; n <= 12 && !done; n++) begin
      if (ifc.mem_W) begin
        o.wcnt++;
        o.wcyc = n;
        o.wd   = ifc.mem_D;
      end
      if (ifc.mem_A !== wa) a_ok = 1'b0;
      if (ifc.rsp_valid) begin
        done    = 1'b1;
        o.lat   = n;
        o.err   = ifc.rsp_err;
        o.rdata = ifc.rsp_rdata;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic cmp(input string tag, input res_t e, input res_t o, input logic a_ok);
    chk({tag, ".rsp_err"}, {31'd0, o.err}, {31'd0, e.err});
    chk({tag, ".rsp_rdata"}, o.rdata, e.rdata);
    chk({tag, ".latency"}, 32'(o.lat), 32'(e.lat));
    chk({tag, ".mem_W_count"}, 32'(o.wcnt), 32'(e.wcnt));
    chk({tag, ".mem_W_cycle"}, 32'(o.wcyc), 32'(e.wcyc));
    if (e.wcnt != 0) chk({tag, ".mem_D_written"}, o.wd, e.wd);
    if (!e.err) chk({tag, ".mem_A_stable"}, {31'd0, a_ok}, 32'd1);
  endtask

  initial begin
    vec_t        tbl[$];
    req_t        r, ra, rb;
    res_t        e, o, ea, eb;
    logic        a_ok;
    int          k;
    int          t[2];
    logic [31:0] d[2];
    int          wc;
    int          seen;

    for (int i = 0; i < 65536; i++) ref_mem[i] = '0;
    r = '{wr: 1'b0, size: 2'd2, sgn: 1'b0, addr: 18'd0, wdata: 32'd0};
    drive(r, 1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset.mem_A", 32'(ifc.mem_A), 32'd0);
    chk("reset.mem_W", {31'd0, ifc.mem_W}, 32'd0);
    chk("reset.mem_D", ifc.mem_D, 32'd0);
    chk("reset.rsp_valid", {31'd0, ifc.rsp_valid}, 32'd0);
    chk("reset.rsp_err", {31'd0, ifc.rsp_err}, 32'd0);
    chk("reset.rsp_rdata", ifc.rsp_rdata, 32'd0);
    chk("reset.req_ready_in_reset", {31'd0, ifc.req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("reset.req_ready_after", {31'd0, ifc.req_ready}, 32'd1);

    // Directed vectors: wr, size, signed, addr, wdata | err, rdata, latency, mem_W cycle, word written
`ifdef LSU_SUBWORD_EN
    tbl.push_back(mk(1, 2'd2, 0, 18'h10, 32'hDEADBEEF, 0, 32'h0,        2, 1, 32'hDEADBEEF));
    tbl.push_back(mk(0, 2'd2, 0, 18'h10, 32'h0,        0, 32'hDEADBEEF, 3, 0, 32'h0));
    tbl.push_back(mk(1, 2'd0, 0, 18'h13, 32'h000000A5, 0, 32'h0,        4, 3, 32'hA5ADBEEF));
    tbl.push_back(mk(0, 2'd2, 0, 18'h10, 32'h0,        0, 32'hA5ADBEEF, 3, 0, 32'h0));
    tbl.push_back(mk(0, 2'd0, 1, 18'h13, 32'h0,        0, 32'hFFFFFFA5, 3, 0, 32'h0));
    tbl.push_back(mk(0, 2'd0, 0, 18'h13, 32'h0,        0, 32'h000000A5, 3, 0, 32'h0));
    tbl.push_back(mk(0, 2'd1, 1, 18'h12, 32'h0,        0, 32'hFFFFA5AD, 3, 0, 32'h0));
    tbl.push_back(mk(0, 2'd1, 0, 18'h10, 32'h0,        0, 32'h0000BEEF, 3, 0, 32'h0));
    tbl.push_back(mk(0, 2'd2, 0, 18'h11, 32'h0,        1, 32'h0,        1, 0, 32'h0));
    tbl.push_back(mk(1, 2'd1, 0, 18'h13, 32'h1234,     1, 32'h0,        1, 0, 32'h0));
    tbl.push_back(mk(0, 2'd3, 0, 18'h10, 32'h0,        0, 32'hA5ADBEEF, 3, 0, 32'h0));
`else
    tbl.push_back(mk(1, 2'd2, 0, 18'h10, 32'hDEADBEEF, 0, 32'h0,        2, 1, 32'hDEADBEEF));
    tbl.push_back(mk(0, 2'd2, 0, 18'h10, 32'h0,        0, 32'hDEADBEEF, 3, 0, 32'h0));
    tbl.push_back(mk(1, 2'd0, 0, 18'h10, 32'h000000A5, 0, 32'h0,        2, 1, 32'h000000A5));
    tbl.push_back(mk(0, 2'd0, 1, 18'h10, 32'h0,        0, 32'h000000A5, 3, 0, 32'h0));
    tbl.push_back(mk(0, 2'd2, 0, 18'h11, 32'h0,        1, 32'h0,        1, 0, 32'h0));
    tbl.push_back(mk(1, 2'd1, 0, 18'h13, 32'h1234,     1, 32'h0,        1, 0, 32'h0));
    tbl.push_back(mk(0, 2'd2, 0, 18'h10, 32'h0,        0, 32'h000000A5, 3, 0, 32'h0));
`endif
    foreach (tbl[i]) begin
      e = model(tbl[i].r);
      do_req(tbl[i].r, o, a_ok);
      cmp($sformatf("vec%0d", i), tbl[i].e, o, a_ok);
    end

    // Reset while the store's memory write is on the port
    @(posedge clk); #1;
`ifdef LSU_SUBWORD_EN
    r  = '{wr: 1'b1, size: 2'd1, sgn: 1'b0, addr: 18'h10, wdata: 32'h0000_1111};
    wc = 3;
`else
    r  = '{wr: 1'b1, size: 2'd2, sgn: 1'b0, addr: 18'h10, wdata: 32'h0BAD_F00D};
    wc = 1;
`endif
    drive(r, 1'b1);
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
    for (int n = 1; n < wc; n++) begin
      @(posedge clk); #1;
    end
    chk("rst_mid.mem_W_before", {31'd0, ifc.mem_W}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid.mem_W_async", {31'd0, ifc.mem_W}, 32'd0);
    chk("rst_mid.rsp_valid_async", {31'd0, ifc.rsp_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst_mid.req_ready_after", {31'd0, ifc.req_ready}, 32'd1);
    seen = 0;
    for (int n = 0; n < 5; n++) begin
      if (ifc.rsp_valid) seen++;
      @(posedge clk); #1;
    end
    chk("rst_mid.no_response", 32'(seen), 32'd0);
    r = '{wr: 1'b0, size: 2'd2, sgn: 1'b0, addr: 18'h10, wdata: 32'd0};
    e = model(r);
    do_req(r, o, a_ok);
    cmp("rst_mid.readback", e, o, a_ok);

    // Back-to-back: second load held on req_valid until the first response cycle
    ra = '{wr: 1'b0, size: 2'd2, sgn: 1'b0, addr: 18'h10, wdata: 32'd0};
`ifdef LSU_SUBWORD_EN
    rb = '{wr: 1'b0, size: 2'd0, sgn: 1'b0, addr: 18'h12, wdata: 32'd0};
`else
    rb = '{wr: 1'b0, size: 2'd2, sgn: 1'b0, addr: 18'h14, wdata: 32'd0};
`endif
    ea = model(ra);
    eb = model(rb);
    k = 0;
    t[0] = -100;
    t[1] = -100;
    d[0] = 'x;
    d[1] = 'x;
    drive(ra, 1'b1);
    @(posedge clk); #1;
    drive(rb, 1'b1);
    for (int c = 1; c <= 14 && k < 2; c++) begin
      if (ifc.rsp_valid) begin
        t[k] = c;
        d[k] = ifc.rsp_rdata;
        if (k == 0) chk("b2b.req_ready_at_rsp1", {31'd0, ifc.req_ready}, 32'd1);
        k++;
      end
      @(posedge clk); #1;
      if (k >= 1) ifc.req_valid = 1'b0;
    end
    chk("b2b.rsp1_latency", 32'(t[0]), 32'(ea.lat));
    chk("b2b.rsp1_rdata", d[0], ea.rdata);
    chk("b2b.rsp2_latency", 32'(t[1] - t[0]), 32'(eb.lat));
    chk("b2b.rsp2_rdata", d[1], eb.rdata);

    // Randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      r.wr    = 1'($urandom_range(0, 1));
      r.size  = 2'($urandom_range(0, 3));
      r.sgn   = 1'($urandom_range(0, 1));
      r.addr  = ($urandom_range(0, 1) != 0 ? 18'h3FFC0 : 18'h0) + 18'($urandom_range(0, 63));
      r.wdata = $urandom;
      e = model(r);
      do_req(r, o, a_ok);
      cmp($sformatf("rnd%0d", i), e, o, a_ok);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Initiator-side port that sequences load/store requests from the pipeline onto the `DP_mem32x64k` word memory port (`A`/`W`/`D`/`Q`). It accepts one request at a time over a valid/ready handshake and converts byte addresses to word addresses. Sub-word stores run as read-modify-write. Read data comes back sign- or zero-extended with a one-cycle response pulse. Sits between the execute/memory stage and the data memory instance.

## Interface
- `ADDR`, 16, memory word-address width (from params.v)
- `WORD`, 32, data width (from params.v)
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted at the edge where `req_valid && req_ready`
- `req_write`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 treated as word
- `req_signed`  in  1  sign-extend load result
- `req_addr`  in  ADDR+2  byte address
- `req_wdata`  in  WORD  store data, right-aligned
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_err`  out  1  qualified by `rsp_valid`: misaligned request
- `rsp_rdata`  out  WORD  load result; 0 for stores and errors
- `mem_A`  out  ADDR  to memory `A` (registered)
- `mem_W`  out  1  to memory `W` (registered)
- `mem_D`  out  WORD  to memory `D` (registered)
- `mem_Q`  in  WORD  from memory `Q`; valid the cycle after `A` is sampled

## Operation
- **Reset state:** state IDLE; `mem_A`, `mem_W`, `mem_D`, `rsp_valid`, `rsp_err` and `rsp_rdata` all 0.
- `req_ready` = (state == IDLE) && !reset.
- **Lane:** `req_addr[1:0]`, little-endian; byte lane n = bits 8n+7:8n. Word address = `req_addr[ADDR+1:2]`.
- **Misaligned:** half with `addr[0]`=1, or word with `addr[1:0]`≠0. Response: `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0, state stays IDLE. No memory access occurs.
- **IDLE accept:**
  - `mem_A` ← word address.
  - `mem_D` ← `req_wdata`.
  - `mem_W` ← 1 only for a word store.
  - Next state is ST_DONE for a word store, RD1 otherwise.
  - Request fields, lane and size are latched.
- **ST_DONE:** `mem_W` ← 0, `rsp_valid` ← 1, go to IDLE.
- **RD1:** `mem_W`=0; the memory samples `mem_A` at the end of this cycle. Go to RD2.
- **RD2:** `mem_Q` is valid.
  - Load: `rsp_rdata` ← lane extracted and extended (sign per `req_signed`), `rsp_valid` ← 1, go to IDLE.
  - Sub-word store: `mem_D` ← `mem_Q` with the addressed lane(s) replaced by the low bits of the latched wdata, `mem_W` ← 1, go to WR.
- **WR:** `mem_W` ← 0, `rsp_valid` ← 1, go to IDLE.
- **Back-to-back:** `rsp_valid` is high for exactly one cycle, in IDLE. A new request may be accepted in that same cycle.
- **Reset mid-operation:** all outputs clear immediately, including `mem_W` mid-write, so the memory word is not written. The in-flight request is dropped with no response.

## Timing
- Cycle +n means n cycles after the accept cycle.
- Latency to `rsp_valid`:
  - misaligned: +1
  - word store: +2
  - load: +3
  - sub-word store: +4
- `mem_W` is high for exactly one cycle per store: +1 for a word store, +3 for a sub-word store. It is never high for loads or errors.
- `mem_A` is held stable from +1 until the response.
- Throughput: one request per response; no pipelining.

## Configuration
- `LSU_SUBWORD_EN` defined:
  - full byte/half/word support as described.
  - RMW path (RD1→RD2→WR) used for sub-word stores.
- `LSU_SUBWORD_EN` undefined:
  - `req_size` and `req_signed` are ignored; every access is a word access.
  - Misaligned means `addr[1:0]`≠0.
  - The WR state and merge logic are not compiled.
  - Loads return the full `mem_Q`.

## Test plan
- **Word store and load:** word store to 0x00010 with 0xDEADBEEF, then word load from 0x00010. Store: `mem_A`=0x0004 and `mem_W`=1 at +1, ack at +2. Load: `rsp_rdata`=0xDEADBEEF at +3, `rsp_err`=0.
- **Byte store (RMW):** byte store of 0x000000A5 to 0x00013 over 0xDEADBEEF, then word load from 0x00010. Store: `mem_W`=1 only at +3, ack at +4. Load returns 0xA5ADBEEF.
- **Sign/zero extension:** with 0xA5ADBEEF stored, expect:
  - signed byte load from 0x00013 → 0xFFFFFFA5
  - unsigned byte load from 0x00013 → 0x000000A5
  - signed half load from 0x00012 → 0xFFFFA5AD
  - unsigned half load from 0x00010 → 0x0000BEEF
- **Misaligned:** word load from 0x00011 and half store to 0x00013. Each gives `rsp_valid`=`rsp_err`=1 at +1 with `rsp_rdata`=0. `mem_W` stays 0 and memory is unchanged.
- **Reset during RMW:** assert `reset` during WR of a half store to 0x00010. `mem_W` drops asynchronously, no `rsp_valid` appears, and the word still reads 0xA5ADBEEF. `req_ready`=1 on the first cycle after release.
- **Back-to-back:** `req_valid` held high with two queued loads. The second is accepted in the same cycle as the first `rsp_valid`, and both return correct data at +3 each.
